usb_cmd_ctrl: RTL and testbench

Command sequencer between the FT245 FIFO engine and the board register bus. It pulls bytes from the PC through the engine's read request, decodes fixed-length register-access commands, and issues single-cycle register strobes. It returns acknowledge or readback bytes through the engine's write request. It is the only master of the engine's request inputs, so read and write requests are never asserted together.

---
 rtl/usb_cmd_pkg.sv | 29 ++
 rtl/usb_timeout_ctr.sv | 44 ++++
 rtl/usb_cmd_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_usb_cmd_ctrl.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module : usb_cmd_pkg
// Brief  : Opcodes, response codes and sequencer states shared by usb_cmd_ctrl.
// Rev    : 1.0
// ============================================================================
package usb_cmd_pkg;

  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;

  localparam logic [7:0] RSP_WACK  = 8'hA5;
  localparam logic [7:0] RSP_RACK  = 8'hA6;
  localparam logic [7:0] RSP_RTMO  = 8'hE1;
  localparam logic [7:0] RSP_BADOP = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_GET_ADDR   = 3'd1,
    S_GET_DATA   = 3'd2,
    S_REG_WR     = 3'd3,
    S_REG_RD     = 3'd4,
    S_RD_WAIT    = 3'd5,
    S_SEND_FIRST = 3'd6,
    S_SEND_LAST  = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/usb_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module : usb_timeout_ctr
// Brief  : Saturating down-counter; tc rises on the CYCLES-th enabled cycle
//          after a clear.
// Rev    : 1.0
// ============================================================================
module usb_timeout_ctr #(
  parameter int unsigned CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int unsigned W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = LOAD;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= LOAD;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/usb_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module : usb_cmd_ctrl
// Brief  : Decodes FT245 command bytes into register strobes and returns
//          acknowledge / readback bytes.
// Rev    : 1.0
// ============================================================================
module usb_cmd_ctrl
  import usb_cmd_pkg::*;
#(
  parameter int unsigned RD_TIMEOUT  = 255,
  parameter int unsigned GAP_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  output logic        _read_data,
  output logic        _write_data,
  output logic [7:0]  data_to_pc,
  input  logic [7:0]  data_to_fpga,
  input  logic        rx_strobe,
  input  logic        tx_strobe,
  output logic [7:0]  reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [7:0]  reg_rdata,
  input  logic        reg_rvalid,
  output logic        busy,
  output logic        err_gap,
  output logic [15:0] cmd_count
);

  state_t      state_q, state_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        is_read_q, is_read_d;
  logic        reg_wr_q, reg_wr_d;
  logic        reg_rd_q, reg_rd_d;
  logic        err_gap_q, err_gap_d;
  logic [15:0] count_q, count_d;

  logic in_rx_gap;
  logic gap_tc;
  logic rd_tc;

  // The gap counter only runs between command bytes, restarting on each byte.
  assign in_rx_gap = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA);

  usb_timeout_ctr #(.CYCLES(GAP_TIMEOUT)) u_gap_ctr (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_rx_gap || rx_strobe),
    .enable (in_rx_gap),
    .tc     (gap_tc)
  );

  usb_timeout_ctr #(.CYCLES(RD_TIMEOUT)) u_rd_ctr (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != S_RD_WAIT),
    .enable (state_q == S_RD_WAIT),
    .tc     (rd_tc)
  );

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    is_read_d = is_read_q;
    count_d   = count_q;
    reg_wr_d  = 1'b0;
    reg_rd_d  = 1'b0;
    err_gap_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_strobe) begin
          if ((data_to_fpga == OP_WRITE) || (data_to_fpga == OP_READ)) begin
            is_read_d = (data_to_fpga == OP_READ);
            state_d   = S_GET_ADDR;
          end else begin
            tx_d    = RSP_BADOP;
            state_d = S_SEND_LAST;
          end
        end
      end
      S_GET_ADDR: begin
        if (rx_strobe) begin
          addr_d = data_to_fpga;
          if (is_read_q) begin
            reg_rd_d = 1'b1;
            state_d  = S_REG_RD;
          end else begin
            state_d  = S_GET_DATA;
          end
        end else if (gap_tc) begin
          err_gap_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_GET_DATA: begin
        if (rx_strobe) begin
          wdata_d  = data_to_fpga;
          reg_wr_d = 1'b1;
          state_d  = S_REG_WR;
        end else if (gap_tc) begin
          err_gap_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_REG_WR: begin
        tx_d    = RSP_WACK;
        state_d = S_SEND_LAST;
      end
      S_REG_RD: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // Readback beats the timeout when both land in the same cycle.
        if (reg_rvalid) begin
          rdata_d = reg_rdata;
          tx_d    = RSP_RACK;
          state_d = S_SEND_FIRST;
        end else if (rd_tc) begin
          tx_d    = RSP_RTMO;
          state_d = S_SEND_LAST;
        end
      end
      S_SEND_FIRST: begin
        if (tx_strobe) begin
          tx_d    = rdata_q;
          state_d = S_SEND_LAST;
        end
      end
      S_SEND_LAST: begin
        if (tx_strobe) begin
          count_d = count_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Request lines follow the next state, so only one can ever be low.
    rd_n_d = !((state_d == S_IDLE) || (state_d == S_GET_ADDR) || (state_d == S_GET_DATA));
    wr_n_d = !((state_d == S_SEND_FIRST) || (state_d == S_SEND_LAST));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      tx_q      <= 8'h00;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      is_read_q <= 1'b0;
      reg_wr_q  <= 1'b0;
      reg_rd_q  <= 1'b0;
      err_gap_q <= 1'b0;
      count_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      is_read_q <= is_read_d;
      reg_wr_q  <= reg_wr_d;
      reg_rd_q  <= reg_rd_d;
      err_gap_q <= err_gap_d;
      count_q   <= count_d;
    end
  end

  assign _read_data  = rd_n_q;
  assign _write_data = wr_n_q;
  assign data_to_pc  = tx_q;
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign reg_wr      = reg_wr_q;
  assign reg_rd      = reg_rd_q;
  assign err_gap     = err_gap_q;
  assign cmd_count   = count_q;
  assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_usb_cmd_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_usb_cmd_ctrl
// Brief  : Directed and randomized command traffic against a byte-level model.
// Rev    : 1.0
// ============================================================================
module tb_usb_cmd_ctrl;

  localparam int RD_TMO  = 8;
  localparam int GAP_TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd_n, wr_n;
  logic [7:0]  data_to_pc;
  logic [7:0]  data_to_fpga = 8'h00;
  logic        rx_strobe = 1'b0;
  logic        tx_strobe = 1'b0;
  logic [7:0]  reg_addr, reg_wdata;
  logic        reg_wr, reg_rd;
  logic [7:0]  reg_rdata = 8'h00;
  logic        reg_rvalid = 1'b0;
  logic        busy, err_gap;
  logic [15:0] cmd_count;

  int          total = 0;
  int          bad = 0;
  int          wr_pulses = 0;
  int          rd_pulses = 0;
  logic [15:0] model_count = 16'h0000;
  logic [7:0]  exp_q[$];
  bit          exp_wr, exp_rd;

  usb_cmd_ctrl #(.RD_TIMEOUT(RD_TMO), .GAP_TIMEOUT(GAP_TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    ._read_data   (rd_n),
    ._write_data  (wr_n),
    .data_to_pc   (data_to_pc),
    .data_to_fpga (data_to_fpga),
    .rx_strobe    (rx_strobe),
    .tx_strobe    (tx_strobe),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_wr       (reg_wr),
    .reg_rd       (reg_rd),
    .reg_rdata    (reg_rdata),
    .reg_rvalid   (reg_rvalid),
    .busy         (busy),
    .err_gap      (err_gap),
    .cmd_count    (cmd_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Strobe-cycle counting and request-line exclusivity on every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (reg_wr === 1'b1) wr_pulses++;
      if (reg_rd === 1'b1) rd_pulses++;
      total++;
      if (rd_n === 1'b0 && wr_n === 1'b0) begin
        bad++;
        $display("FAIL req_exclusive: _read_data=%b _write_data=%b, required not both 0", rd_n, wr_n);
      end
    end
  end

  // Reference: what the PC sees for one command, from opcode and readback timing.
  function automatic void model_cmd(input logic [7:0] op, input logic [7:0] rdv, input int dly);
    exp_q.delete();
    exp_wr = 1'b0;
    exp_rd = 1'b0;
    if (op == 8'h01) begin
      exp_wr = 1'b1;
      exp_q.push_back(8'hA5);
    end else if (op == 8'h02) begin
      exp_rd = 1'b1;
      if (dly <= RD_TMO) begin
        exp_q.push_back(8'hA6);
        exp_q.push_back(rdv);
      end else begin
        exp_q.push_back(8'hE1);
      end
    end else begin
      exp_q.push_back(8'hEE);
    end
    model_count = model_count + 16'd1;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int idle);
    int n = 0;
    repeat (idle) @(negedge clk);
    while (rd_n !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (rd_n !== 1'b0) begin
      bad++;
      $display("FAIL rx_request: _read_data=%b after %0d cycles, required 0", rd_n, n);
      @(negedge clk);
    end else begin
      rx_strobe = 1'b1;
      data_to_fpga = b;
      @(negedge clk);
      rx_strobe = 1'b0;
    end
  endtask

  task automatic get_resp(input int hold, output logic [7:0] b, output bit stable);
    int n = 0;
    while (wr_n !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    b = data_to_pc;
    stable = (wr_n === 1'b0);
    if (stable) begin
      repeat (hold) begin
        @(negedge clk);
        if (data_to_pc !== b || wr_n !== 1'b0) stable = 1'b0;
      end
      tx_strobe = 1'b1;
      @(negedge clk);
      tx_strobe = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (rd_n !== 1'b1 || wr_n !== 1'b1 || busy !== 1'b0 || err_gap !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: rd_n=%b wr_n=%b busy=%b err_gap=%b, required 1 1 0 0", rd_n, wr_n, busy, err_gap);
    end
    total++;
    if (data_to_pc !== 8'h00 || reg_addr !== 8'h00 || reg_wdata !== 8'h00 ||
        reg_wr !== 1'b0 || reg_rd !== 1'b0 || cmd_count !== 16'h0000) begin
      bad++;
      $display("FAIL reset_data: tx=%h addr=%h wdata=%h wr=%b rd=%b count=%h, required all 0",
               data_to_pc, reg_addr, reg_wdata, reg_wr, reg_rd, cmd_count);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (rd_n !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_request: rd_n=%b busy=%b, required 0 0", rd_n, busy);
    end
  endtask

  task automatic test_write();
    logic [7:0] got;
    bit st;
    send_byte(8'h01, 0);
    send_byte(8'h10, 2);
    send_byte(8'h5A, 1);
    total++;
    if (reg_wr !== 1'b1 || reg_addr !== 8'h10 || reg_wdata !== 8'h5A) begin
      bad++;
      $display("FAIL write_strobe: wr=%b addr=%h wdata=%h, required 1 10 5a", reg_wr, reg_addr, reg_wdata);
    end
    @(negedge clk);
    total++;
    if (reg_wr !== 1'b0) begin
      bad++;
      $display("FAIL write_width: reg_wr=%b one cycle later, required 0", reg_wr);
    end
    get_resp(2, got, st);
    total++;
    if (got !== 8'hA5 || !st) begin
      bad++;
      $display("FAIL write_ack: got %h stable=%0d, required a5 stable=1", got, st);
    end
    model_count = model_count + 16'd1;
    total++;
    if (cmd_count !== model_count) begin
      bad++;
      $display("FAIL write_count: cmd_count=%0d, required %0d", cmd_count, model_count);
    end
  endtask

  task automatic test_read();
    logic [7:0] got;
    bit st;
    send_byte(8'h02, 0);
    send_byte(8'h22, 1);
    total++;
    if (reg_rd !== 1'b1 || reg_addr !== 8'h22) begin
      bad++;
      $display("FAIL read_strobe: rd=%b addr=%h, required 1 22", reg_rd, reg_addr);
    end
    repeat (3) @(negedge clk);
    reg_rvalid = 1'b1;
    reg_rdata = 8'h3C;
    @(negedge clk);
    reg_rvalid = 1'b0;
    get_resp(1, got, st);
    total++;
    if (got !== 8'hA6 || !st) begin
      bad++;
      $display("FAIL read_ack: got %h stable=%0d, required a6 stable=1", got, st);
    end
    total++;
    if (wr_n !== 1'b0) begin
      bad++;
      $display("FAIL read_hold_req: _write_data=%b between bytes, required 0", wr_n);
    end
    get_resp(0, got, st);
    total++;
    if (got !== 8'h3C || !st) begin
      bad++;
      $display("FAIL read_data: got %h stable=%0d, required 3c stable=1", got, st);
    end
    model_count = model_count + 16'd1;
    total++;
    if (wr_n !== 1'b1 || cmd_count !== model_count) begin
      bad++;
      $display("FAIL read_done: wr_n=%b cmd_count=%0d, required 1 %0d", wr_n, cmd_count, model_count);
    end
  endtask

  task automatic test_read_timeout();
    logic [7:0] got;
    bit st;
    send_byte(8'h02, 0);
    send_byte(8'h22, 0);
    repeat (RD_TMO) @(negedge clk);
    total++;
    if (wr_n !== 1'b1) begin
      bad++;
      $display("FAIL tmo_early: _write_data=%b in last wait cycle, required 1", wr_n);
    end
    @(negedge clk);
    total++;
    if (wr_n !== 1'b0 || data_to_pc !== 8'hE1) begin
      bad++;
      $display("FAIL tmo_resp: wr_n=%b tx=%h, required 0 e1", wr_n, data_to_pc);
    end
    reg_rvalid = 1'b1;
    reg_rdata = 8'h55;
    @(negedge clk);
    reg_rvalid = 1'b0;
    get_resp(2, got, st);
    total++;
    if (got !== 8'hE1 || !st) begin
      bad++;
      $display("FAIL tmo_late_rvalid: got %h stable=%0d, required e1 stable=1", got, st);
    end
    model_count = model_count + 16'd1;
    total++;
    if (cmd_count !== model_count || wr_n !== 1'b1) begin
      bad++;
      $display("FAIL tmo_count: cmd_count=%0d wr_n=%b, required %0d 1", cmd_count, wr_n, model_count);
    end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] got;
    bit st;
    int bw, br;
    bw = wr_pulses;
    br = rd_pulses;
    send_byte(8'h7F, 0);
    get_resp(1, got, st);
    total++;
    if (got !== 8'hEE || !st) begin
      bad++;
      $display("FAIL badop_resp: got %h stable=%0d, required ee stable=1", got, st);
    end
    send_byte(8'h01, 0);
    send_byte(8'h44, 0);
    send_byte(8'h99, 0);
    total++;
    if (reg_wr !== 1'b1 || reg_addr !== 8'h44 || reg_wdata !== 8'h99) begin
      bad++;
      $display("FAIL badop_next: wr=%b addr=%h wdata=%h, required 1 44 99", reg_wr, reg_addr, reg_wdata);
    end
    get_resp(0, got, st);
    total++;
    if (got !== 8'hA5) begin
      bad++;
      $display("FAIL badop_next_ack: got %h, required a5", got);
    end
    model_count = model_count + 16'd2;
    total++;
    if (wr_pulses - bw != 1 || rd_pulses - br != 0 || cmd_count !== model_count) begin
      bad++;
      $display("FAIL badop_strobes: wr=%0d rd=%0d count=%0d, required 1 0 %0d",
               wr_pulses - bw, rd_pulses - br, cmd_count, model_count);
    end
  endtask

  task automatic test_gap_and_reset();
    send_byte(8'h01, 0);
    repeat (GAP_TMO - 1) @(negedge clk);
    total++;
    if (err_gap !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL gap_early: err_gap=%b busy=%b, required 0 1", err_gap, busy);
    end
    @(negedge clk);
    total++;
    if (err_gap !== 1'b1 || busy !== 1'b0 || wr_n !== 1'b1) begin
      bad++;
      $display("FAIL gap_pulse: err_gap=%b busy=%b wr_n=%b, required 1 0 1", err_gap, busy, wr_n);
    end
    @(negedge clk);
    total++;
    if (err_gap !== 1'b0 || wr_n !== 1'b1 || cmd_count !== model_count) begin
      bad++;
      $display("FAIL gap_after: err_gap=%b wr_n=%b count=%0d, required 0 1 %0d",
               err_gap, wr_n, cmd_count, model_count);
    end
    send_byte(8'h01, 0);
    send_byte(8'h33, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (rd_n !== 1'b1 || wr_n !== 1'b1 || busy !== 1'b0 || err_gap !== 1'b0 ||
        data_to_pc !== 8'h00 || reg_addr !== 8'h00 || reg_wdata !== 8'h00 ||
        reg_wr !== 1'b0 || reg_rd !== 1'b0 || cmd_count !== 16'h0000) begin
      bad++;
      $display("FAIL reset_mid_cmd: rd_n=%b wr_n=%b busy=%b gap=%b tx=%h addr=%h wdata=%h wr=%b rd=%b count=%h, required 1 1 0 0 00 00 00 0 0 0000",
               rd_n, wr_n, busy, err_gap, data_to_pc, reg_addr, reg_wdata, reg_wr, reg_rd, cmd_count);
    end
    @(negedge clk);
    reset = 1'b0;
    model_count = 16'h0000;
    repeat (3) @(negedge clk);
    total++;
    if (wr_n !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_resp: wr_n=%b busy=%b, required 1 0", wr_n, busy);
    end
  endtask

  task automatic test_random_cmds(input int n, input int idle_max, input int hold_max);
    logic [7:0] op, addr, wd, rdv, got;
    int dly, bw, br, r;
    bit st;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      op = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : 8'($urandom_range(3, 255));
      addr = 8'($urandom);
      wd = 8'($urandom);
      rdv = 8'($urandom);
      dly = $urandom_range(1, RD_TMO + 4);
      model_cmd(op, rdv, dly);
      bw = wr_pulses;
      br = rd_pulses;
      send_byte(op, $urandom_range(0, idle_max));
      if (op == 8'h01 || op == 8'h02) send_byte(addr, $urandom_range(0, idle_max));
      if (op == 8'h01) send_byte(wd, $urandom_range(0, idle_max));
      if (exp_wr) begin
        total++;
        if (reg_wr !== 1'b1 || reg_addr !== addr || reg_wdata !== wd) begin
          bad++;
          $display("FAIL rnd_write[%0d]: wr=%b addr=%h wdata=%h, required 1 %h %h", i, reg_wr, reg_addr, reg_wdata, addr, wd);
        end
      end
      if (exp_rd) begin
        total++;
        if (reg_rd !== 1'b1 || reg_addr !== addr) begin
          bad++;
          $display("FAIL rnd_read[%0d]: rd=%b addr=%h, required 1 %h", i, reg_rd, reg_addr, addr);
        end
        repeat (dly) @(negedge clk);
        reg_rvalid = 1'b1;
        reg_rdata = rdv;
        @(negedge clk);
        reg_rvalid = 1'b0;
      end
      for (int k = 0; k < exp_q.size(); k++) begin
        get_resp($urandom_range(0, hold_max), got, st);
        total++;
        if (got !== exp_q[k] || !st) begin
          bad++;
          $display("FAIL rnd_resp[%0d.%0d]: got %h stable=%0d, required %h stable=1", i, k, got, st, exp_q[k]);
        end
        total++;
        if (wr_n !== ((k == exp_q.size() - 1) ? 1'b1 : 1'b0)) begin
          bad++;
          $display("FAIL rnd_req[%0d.%0d]: _write_data=%b after tx_strobe, required %b",
                   i, k, wr_n, (k == exp_q.size() - 1) ? 1'b1 : 1'b0);
        end
      end
      total++;
      if (cmd_count !== model_count || (wr_pulses - bw) != int'(exp_wr) || (rd_pulses - br) != int'(exp_rd)) begin
        bad++;
        $display("FAIL rnd_done[%0d]: count=%0d wr=%0d rd=%0d, required %0d %0d %0d",
                 i, cmd_count, wr_pulses - bw, rd_pulses - br, model_count, exp_wr, exp_rd);
      end
    end
  endtask

  task automatic test_back_to_back();
    test_random_cmds(12, 0, 0);
  endtask

  initial begin
    void'($urandom(32'h00C0FFEE));
    #1;
    test_reset();
    test_write();
    test_read();
    test_read_timeout();
    test_bad_opcode();
    test_gap_and_reset();
    test_random_cmds(30, 10, 4);
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
